control_fsm: RTL and testbench
==============================

# control_fsm

Multicycle control unit for the RV32I core. It sits directly upstream of the instruction decoder/extend stage: it takes opcode/funct fields from the instruction register and drives `immSrc` into the extend logic. It also drives every datapath enable and mux select through a Moore main FSM, plus a combinational ALU decoder. It supports lw, sw, R-type ALU, I-type ALU, beq and jal; any other opcode is flagged illegal and skipped.

## Interface
Parameters: none; all encodings come from the shared constants file.

- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high. The FSM returns to FETCH immediately.
- `op` input 7: instruction[6:0].
- `funct3` input 3: instruction[14:12].
- `funct7b5` input 1: instruction[30].
- `zero` input 1: ALU zero flag from the current cycle.
- `pcWrite` output 1: PC register enable.
- `adrSrc` output 1: memory address mux. 0 = PC, 1 = ALUOut.
- `memWrite` output 1: data memory write enable.
- `irWrite` output 1: instruction register and oldPC enable.
- `regWrite` output 1: register file write enable.
- `resultSrc` output 2: result mux. 00 = ALUOut, 01 = read data, 10 = ALU result.
- `aluSrcA` output 2: ALU input A mux. 00 = PC, 01 = oldPC, 10 = rs1 data.
- `aluSrcB` output 2: ALU input B mux. 00 = rs2 data, 01 = immext, 10 = constant 4.
- `aluControl` output 3: ALU operation. 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- `immSrc` output 2: extend type. 00 = I, 01 = S, 10 = B, 11 = J.
- `illegal` output 1: high for the DECODE cycle of an unsupported opcode.

## Operation
- States:
  - FETCH
  - DECODE
  - MEMADR
  - MEMREAD
  - MEMWB
  - MEMWRITE
  - EXECUTER
  - EXECUTEI
  - ALUWB
  - BEQ
  - JAL
- All outputs are Moore outputs of state, except:
  - `immSrc` and `illegal` are functions of `op`;
  - `aluControl` also uses `funct3`, `funct7b5` and `op[5]`;
  - `pcWrite` also uses `zero`.
- Any output not listed for a state is 0.
- `pcWrite = pcUpdate | (branch & zero)`. `pcUpdate` and `branch` are internal state decodes.
- FETCH:
  - adrSrc=0, irWrite=1, aluSrcA=00, aluSrcB=10, aluOp=00, resultSrc=10, pcUpdate=1.
  - Next state: DECODE.
- DECODE:
  - aluSrcA=01, aluSrcB=01, aluOp=00. This computes the branch target.
  - Next state: lw/sw (0000011/0100011) → MEMADR; 0110011 → EXECUTER; 0010011 → EXECUTEI; 1100011 → BEQ; 1101111 → JAL; otherwise → FETCH with `illegal`=1.
- MEMADR:
  - aluSrcA=10, aluSrcB=01, aluOp=00.
  - Next state: MEMREAD if op[5]=0, otherwise MEMWRITE.
- MEMREAD: resultSrc=00, adrSrc=1. Next state: MEMWB.
- MEMWB: resultSrc=01, regWrite=1. Next state: FETCH.
- MEMWRITE: resultSrc=00, adrSrc=1, memWrite=1. Next state: FETCH.
- EXECUTER: aluSrcA=10, aluSrcB=00, aluOp=10. Next state: ALUWB.
- EXECUTEI: aluSrcA=10, aluSrcB=01, aluOp=10. Next state: ALUWB.
- ALUWB: resultSrc=00, regWrite=1. Next state: FETCH.
- BEQ:
  - aluSrcA=10, aluSrcB=00, aluOp=01, resultSrc=00, branch=1.
  - Next state: FETCH.
- JAL:
  - aluSrcA=01, aluSrcB=10, aluOp=00, resultSrc=00, pcUpdate=1.
  - Next state: ALUWB.
- ALU decoder:
  - aluOp 00 → add; aluOp 01 → sub.
  - aluOp 10, funct3 000: sub if {op[5],funct7b5}=11, otherwise add.
  - aluOp 10, funct3 010 → slt; 110 → or; 111 → and.
  - aluOp 10 with any other funct3 → add.
  - aluOp 11 → add.
- immSrc decode by `op`: 0000011/0010011 → 00; 0100011 → 01; 1100011 → 10; 1101111 → 11; default → 00.

## Timing
- Reset:
  - State is FETCH asynchronously.
  - While `reset` is high the outputs are the FETCH values: irWrite=1, pcWrite=1, adrSrc=0, resultSrc=10, aluSrcA=00, aluSrcB=10, aluControl=000, all other enables 0.
  - PC and IR have their own reset, so writes during reset are harmless.
- Deassert reset: the first rising edge leaves FETCH.
- Reset during any state aborts the instruction. No memWrite or regWrite may appear after reset asserts.
- Cycles per instruction, FETCH to return to FETCH inclusive:
  - lw 5.
  - sw 4.
  - R-type 4.
  - I-type 4.
  - jal 4.
  - beq 3.
  - illegal 2.
- `zero` is sampled combinationally in BEQ only. A `zero` glitch in any other state has no effect on `pcWrite`.
- `op`/`funct` must stay stable from DECODE through the final state. The IR holds them because irWrite=0 outside FETCH.

## Structure
- Shared constants file:
  - state encodings (4-bit);
  - opcode constants;
  - aluControl codes;
  - immSrc codes;
  - result/src mux codes.
- One sub-module: `alu_decoder` (aluOp, funct3, funct7b5, op5 → aluControl).
- Main FSM and immSrc decode live in `control_fsm`.

## Test plan
- Reset for 3 cycles, then release:
  - during reset, outputs equal the FETCH values;
  - after 1 edge, state is DECODE with aluSrcA=01, aluSrcB=01.
- lw (op=0000011):
  - states FETCH, DECODE, MEMADR, MEMREAD, MEMWB;
  - regWrite=1 and resultSrc=01 only in cycle 5;
  - immSrc=00 throughout.
- sw (op=0100011):
  - memWrite=1 exactly in cycle 4 with adrSrc=1;
  - immSrc=01;
  - no regWrite.
- R-type sub (funct3=000, funct7b5=1):
  - aluControl=001 in EXECUTER;
  - the same with op=0010011 gives aluControl=000 (addi).
  - funct3=110/111/010 give 011/010/101.
- beq:
  - zero=1 gives pcWrite=1 in cycle 3;
  - zero=0 gives pcWrite=0;
  - immSrc=10;
  - aluControl=001.
- jal:
  - FETCH, DECODE, JAL (pcWrite=1), ALUWB (regWrite=1), immSrc=11.
- op=1111111:
  - illegal=1 in DECODE, then FETCH.
- Reset asserted mid-MEMWRITE:
  - memWrite drops immediately;
  - FETCH outputs are driven.

Source files
------------

// File: rtl/control_fsm_pkg.sv
// rtl/control_fsm_pkg.sv - shared encodings for the RV32I multicycle control unit
package control_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Extend type for the opcode currently held in the IR; unknown opcodes fall back to I.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_LW, OP_ITYPE: return IMM_I;
      OP_SW:           return IMM_S;
      OP_BEQ:          return IMM_B;
      OP_JAL:          return IMM_J;
      default:         return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/control_fsm_alu_decoder.sv
// rtl/control_fsm_alu_decoder.sv - maps aluOp and funct fields to the ALU operation
module alu_decoder
  import control_fsm_pkg::*;
(
  input  logic [1:0] aluOp,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] aluControl
);

  // Only aluOp=10 looks at funct; op5 separates R-type sub from addi with a set imm bit.
  always_comb begin
    aluControl = ALU_ADD;
    case (aluOp)
      ALUOP_SUB: aluControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  aluControl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  aluControl = ALU_SLT;
          3'b110:  aluControl = ALU_OR;
          3'b111:  aluControl = ALU_AND;
          default: aluControl = ALU_ADD;
        endcase
      end
      default: aluControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// rtl/control_fsm.sv - Moore main FSM and immSrc decode for the RV32I multicycle core
module control_fsm
  import control_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pcWrite,
  output logic       adrSrc,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regWrite,
  output logic [1:0] resultSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [2:0] aluControl,
  output logic [1:0] immSrc,
  output logic       illegal
);

  state_t     state, state_next;
  logic       pcUpdate;
  logic       branch;
  logic [1:0] aluOp;

  // State register; reset forces FETCH at once so a pending write is dropped immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // Next-state and Moore output decode; illegal is the only DECODE output tied to op.
  always_comb begin
    state_next = state;
    adrSrc     = 1'b0;
    memWrite   = 1'b0;
    irWrite    = 1'b0;
    regWrite   = 1'b0;
    resultSrc  = RES_ALUOUT;
    aluSrcA    = SRCA_PC;
    aluSrcB    = SRCB_RS2;
    aluOp      = ALUOP_ADD;
    pcUpdate   = 1'b0;
    branch     = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        irWrite    = 1'b1;
        aluSrcB    = SRCB_FOUR;
        resultSrc  = RES_ALURESULT;
        pcUpdate   = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECUTER;
          OP_ITYPE:     state_next = S_EXECUTEI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default: begin
            state_next = S_FETCH;
            illegal    = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        aluSrcA    = SRCA_RS1;
        aluSrcB    = SRCB_IMM;
        state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adrSrc     = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        resultSrc  = RES_READDATA;
        regWrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        adrSrc     = 1'b1;
        memWrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_EXECUTER: begin
        aluSrcA    = SRCA_RS1;
        aluSrcB    = SRCB_RS2;
        aluOp      = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        aluSrcA    = SRCA_RS1;
        aluSrcB    = SRCB_IMM;
        aluOp      = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        regWrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQ: begin
        aluSrcA    = SRCA_RS1;
        aluSrcB    = SRCB_RS2;
        aluOp      = ALUOP_SUB;
        branch     = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL: begin
        aluSrcA    = SRCA_OLDPC;
        aluSrcB    = SRCB_FOUR;
        pcUpdate   = 1'b1;
        state_next = S_ALUWB;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // zero only matters while branch is decoded, so glitches elsewhere never reach the PC.
  assign pcWrite = pcUpdate | (branch & zero);
  assign immSrc  = imm_src_of(op);

  alu_decoder u_alu_decoder (
    .aluOp      (aluOp),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .op5        (op[5]),
    .aluControl (aluControl)
  );

endmodule

// File: tb/tb_control_fsm.sv
// tb/tb_control_fsm.sv - scoreboard bench for control_fsm against a per-instruction cycle model
module tb_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'b0000011;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, illegal;
  logic [1:0] resultSrc, aluSrcA, aluSrcB, immSrc;
  logic [2:0] aluControl;

  control_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .pcWrite    (pcWrite),
    .adrSrc     (adrSrc),
    .memWrite   (memWrite),
    .irWrite    (irWrite),
    .regWrite   (regWrite),
    .resultSrc  (resultSrc),
    .aluSrcA    (aluSrcA),
    .aluSrcB    (aluSrcB),
    .aluControl (aluControl),
    .immSrc     (immSrc),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] v;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;

  // {pcWrite, adrSrc, memWrite, irWrite, regWrite, resultSrc, aluSrcA, aluSrcB, aluControl, immSrc, illegal}
  function automatic logic [16:0] actual();
    return {pcWrite, adrSrc, memWrite, irWrite, regWrite, resultSrc,
            aluSrcA, aluSrcB, aluControl, immSrc, illegal};
  endfunction

  // Instruction class: 0 lw, 1 sw, 2 R, 3 I, 4 beq, 5 jal, 6 illegal
  function automatic int cls_of(input logic [6:0] o);
    case (o)
      7'b0000011: return 0;
      7'b0100011: return 1;
      7'b0110011: return 2;
      7'b0010011: return 3;
      7'b1100011: return 4;
      7'b1101111: return 5;
      default:    return 6;
    endcase
  endfunction

  function automatic int cpi_of(input int c);
    case (c)
      0: return 5;
      1, 2, 3, 5: return 4;
      4: return 3;
      default: return 2;
    endcase
  endfunction

  // ALU operation requested by an R/I-type instruction.
  function automatic logic [2:0] fn_of(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0: return (o[5] && f7) ? 3'b001 : 3'b000;
      3'd2: return 3'b101;
      3'd6: return 3'b011;
      3'd7: return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Expected outputs for cycle 'step' (0 = fetch cycle) of one instruction.
  function automatic logic [16:0] ref_out(input logic [6:0] o, input logic [2:0] f3,
                                          input logic f7, input logic z, input int step);
    logic       pcw = 0, adr = 0, memw = 0, irw = 0, regw = 0, ill = 0;
    logic [1:0] res = 0, sa = 0, sb = 0, imm;
    logic [2:0] alu = 0;
    int         c = cls_of(o);
    case (c)
      1: imm = 2'b01;
      4: imm = 2'b10;
      5: imm = 2'b11;
      default: imm = 2'b00;
    endcase
    if (step == 0) begin
      pcw = 1; irw = 1; sb = 2; res = 2;
    end else if (step == 1) begin
      sa = 1; sb = 1; ill = (c == 6);
    end else begin
      case (c)
        0: begin
          if (step == 2) begin sa = 2; sb = 1; end
          else if (step == 3) adr = 1;
          else begin res = 1; regw = 1; end
        end
        1: begin
          if (step == 2) begin sa = 2; sb = 1; end
          else begin adr = 1; memw = 1; end
        end
        2: begin
          if (step == 2) begin sa = 2; alu = fn_of(o, f3, f7); end
          else regw = 1;
        end
        3: begin
          if (step == 2) begin sa = 2; sb = 1; alu = fn_of(o, f3, f7); end
          else regw = 1;
        end
        4: begin sa = 2; alu = 3'b001; pcw = z; end
        5: begin
          if (step == 2) begin sa = 1; sb = 2; pcw = 1; end
          else regw = 1;
        end
        default: ;
      endcase
    end
    return {pcw, adr, memw, irw, regw, res, sa, sb, alu, imm, ill};
  endfunction

  // Monitor: the DUT presents a full control word every cycle; compare it on the falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [16:0] a;
      e = q.pop_front();
      a = actual();
      checks++;
      if (a === e.v) passes++;
      else $display("FAIL %s: got %05h expected %05h", e.tag, a, e.v);
    end
  end

  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      reset = 1'b1;
      q.push_back('{ref_out(op, funct3, funct7b5, zero, 0), "reset_fetch"});
    end
  endtask

  // zmode 0/1 forces zero, 2 randomises it every cycle; abort_step >= 0 asserts reset mid-instruction.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int zmode, input int abort_step);
    int n = cpi_of(cls_of(o));
    for (int s = 0; s < n; s++) begin
      @(posedge clk); #1;
      if (s == 0) begin
        reset = 1'b0;
        op = o; funct3 = f3; funct7b5 = f7;
      end
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      q.push_back('{ref_out(o, f3, f7, zero, s), $sformatf("op%07b_s%0d", o, s)});
      if (s == abort_step) begin
        logic [16:0] a, e;
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        a = actual();
        e = ref_out(o, f3, f7, zero, 0);
        checks++;
        if (a === e) passes++;
        else $display("FAIL async_reset_abort: got %05h expected %05h", a, e);
        hold_reset(2);
        return;
      end
    end
  endtask

  logic [6:0] d_op[12] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b0110011,
                           7'b0110011, 7'b0110011, 7'b1100011, 7'b1100011, 7'b1101111,
                           7'b1111111, 7'b0010011};
  logic [2:0] d_f3[12] = '{3'd2, 3'd2, 3'd0, 3'd0, 3'd6, 3'd7, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7};
  logic       d_f7[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  int         d_z[12]  = '{2, 2, 2, 2, 2, 2, 2, 1, 0, 2, 2, 2};

  logic [6:0] legal_ops[6] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                               7'b1100011, 7'b1101111};

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    hold_reset(3);
    for (int i = 0; i < 12; i++)
      run_instr(d_op[i], d_f3[i], d_f7[i], d_z[i], -1);
    for (int i = 0; i < 60; i++) begin
      logic [6:0] o;
      o = ($urandom_range(0, 7) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 5)];
      run_instr(o, 3'($urandom), 1'($urandom), 2, -1);
    end
    run_instr(7'b0100011, 3'd2, 1'b0, 2, 3);
    run_instr(7'b0000011, 3'd2, 1'b0, 2, -1);
    run_instr(7'b0000011, 3'd2, 1'b0, 2, 2);
    run_instr(7'b1101111, 3'd0, 1'b0, 2, -1);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
